// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Contents: halt opcode, fetch FSM state type, prefetch queue entry type,
// and a helper that recognises a halt word.
package if_pkg;

    localparam int unsigned XLEN     = 16;
    localparam logic [3:0]  HALT_OPC = 4'hF;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } if_entry_t;

    // True when the word's opcode field is the halt opcode.
    function automatic logic is_halt(input logic [XLEN-1:0] word);
        return word[XLEN-1:XLEN-4] == HALT_OPC;
    endfunction

endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// Bus bundle between the fetch controller, instruction memory and decode.
//   im_addr/im_rd_en/im_instr       : instruction memory read port
//   if_instr/if_pc/if_valid/if_ready: head-of-queue handshake to decode
//   redirect/redirect_pc            : branch/jump redirect from later stages
//   halted, perf_fetched, perf_bubbles : status and performance counters
// master = fetch controller, slave = surrounding environment.
interface instr_fetch_ctrl_if;

    logic [15:0] im_addr;
    logic        im_rd_en;
    logic [15:0] im_instr;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        if_valid;
    logic        if_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halted;
    logic [15:0] perf_fetched;
    logic [15:0] perf_bubbles;

    modport master (
        output im_addr, im_rd_en, if_instr, if_pc, if_valid,
               halted, perf_fetched, perf_bubbles,
        input  im_instr, if_ready, redirect, redirect_pc
    );

    modport slave (
        input  im_addr, im_rd_en, if_instr, if_pc, if_valid,
               halted, perf_fetched, perf_bubbles,
        output im_instr, if_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_ctrl_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO of {pc, instr} entries.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   flush      : drop all entries (wins over push/pop)
//   push/push_data : enqueue one entry
//   pop        : dequeue head (caller guarantees valid)
//   head/valid : head entry and non-empty flag
//   count      : number of entries held
// DEPTH must be a power of two (pointers wrap naturally).
module if_prefetch_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  if_entry_t                push_data,
    input  logic                     pop,
    output if_entry_t                head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    if_entry_t         mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     cnt;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '{default: '0};
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign valid = (cnt != '0);
    assign count = cnt;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, issues one-cycle-latency reads
// to instruction memory, queues responses and presents them to decode.
// Handles decode back-pressure, branch redirects and halt detection.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : instr_fetch_ctrl_if.master (IM read port, decode handshake,
//          redirect, halted, perf counters)
// Build option: define IF_PERF_CNT_EN to get saturating perf_fetched /
// perf_bubbles counters; otherwise both read as zero.
module instr_fetch_ctrl
    import if_pkg::*;
#(
    parameter int unsigned DEPTH    = 2,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic                      clk,
    input  logic                      rst,
    instr_fetch_ctrl_if.master        bus
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = CW + 1;

    fetch_state_t    state;
    logic [15:0]     fetch_pc;
    logic            inflight;
    logic            discard;

    if_entry_t       head;
    logic            head_valid;
    logic [CW-1:0]   count;

    logic            pop_c;
    logic            capture_c;
    logic            halt_hit_c;
    logic            issue_c;
    logic [OW-1:0]   occ_c;
    logic [OW-1:0]   limit_c;
    if_entry_t       push_data_c;

    // Decode handshake and response capture; a redirect kills the arriving word.
    assign pop_c       = head_valid & bus.if_ready;
    assign capture_c   = inflight & ~discard & ~bus.redirect;
    assign halt_hit_c  = capture_c & is_halt(bus.im_instr);
    assign push_data_c = '{pc: fetch_pc - 16'd1, instr: bus.im_instr};

    // Issue only if the response is guaranteed a slot, counting this cycle's pop.
    assign occ_c   = OW'(count) + OW'(inflight);
    assign limit_c = OW'(DEPTH) + OW'(pop_c);
    assign issue_c = ~rst & (state == RUN) & ~bus.redirect & (occ_c < limit_c);

    // The memory port must see the read in the same cycle the slot is known free.
    assign bus.im_rd_en = issue_c;
    assign bus.im_addr  = fetch_pc;

    // PC, in-flight tracking and RUN/HALTED state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            fetch_pc <= RESET_PC;
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            inflight <= issue_c;
            // A read issued alongside the HLT capture is behind the halt.
            discard  <= issue_c & halt_hit_c;
            if (bus.redirect) begin
                fetch_pc <= bus.redirect_pc;
                state    <= RUN;
            end else begin
                if (issue_c) begin
                    fetch_pc <= fetch_pc + 16'd1;
                end
                case (state)
                    RUN:    if (halt_hit_c) state <= HALTED;
                    HALTED: state <= HALTED;
                endcase
            end
        end
    end

    if_prefetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect),
        .push      (capture_c),
        .push_data (push_data_c),
        .pop       (pop_c),
        .head      (head),
        .valid     (head_valid),
        .count     (count)
    );

    assign bus.if_instr = head.instr;
    assign bus.if_pc    = head.pc;
    assign bus.if_valid = head_valid;
    assign bus.halted   = (state == HALTED);

`ifdef IF_PERF_CNT_EN
    logic [15:0] fetched_q;
    logic [15:0] bubbles_q;

    // Saturating pop and starvation counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (pop_c && fetched_q != 16'hFFFF) begin
                fetched_q <= fetched_q + 16'd1;
            end
            if (bus.if_ready && !head_valid && state == RUN && bubbles_q != 16'hFFFF) begin
                bubbles_q <= bubbles_q + 16'd1;
            end
        end
    end

    assign bus.perf_fetched = fetched_q;
    assign bus.perf_bubbles = bubbles_q;
`else
    assign bus.perf_fetched = 16'h0000;
    assign bus.perf_bubbles = 16'h0000;
`endif

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: directed scenarios plus random
// back-pressure/redirect traffic, checked every cycle against a queue-based
// model of the fetch rules.
module tb_instr_fetch_ctrl;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_ctrl_if bus();

    instr_fetch_ctrl #(
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory: data appears the cycle after a read strobe.
    logic [15:0] mem [0:65535];
    always @(posedge clk) if (bus.im_rd_en) bus.im_instr <= mem[bus.im_addr];

    int vecs = 0;
    int errs = 0;

    typedef struct packed { logic [15:0] pc; logic [15:0] instr; } ment_t;
    typedef struct packed { logic [15:0] addr; logic disc; } mrd_t;

    ment_t       mq[$];
    mrd_t        mp[$];
    logic [15:0] m_fpc;
    bit          m_halt;
    logic [15:0] m_fet, m_bub;

    logic        obs_valid, obs_rd_en, obs_halted;
    logic [15:0] obs_pc, obs_addr, obs_fet, obs_bub;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        mp.delete();
        m_fpc  = 16'h0000;
        m_halt = 1'b0;
        m_fet  = 16'h0000;
        m_bub  = 16'h0000;
    endfunction

    // One clock cycle: apply inputs, compare mid-cycle, advance the model.
    task automatic step(input logic rdy, input logic rd, input logic [15:0] rpc);
        bit    pop, issue, hlt;
        int    occ;
        ment_t e;
        mrd_t  r;
        bus.if_ready    = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        @(negedge clk);
        pop   = (mq.size() > 0) && rdy;
        occ   = mq.size() + mp.size() - int'(pop);
        issue = !m_halt && !rd && (occ < DEPTH);
        obs_valid  = bus.if_valid;
        obs_rd_en  = bus.im_rd_en;
        obs_halted = bus.halted;
        obs_pc     = bus.if_pc;
        obs_addr   = bus.im_addr;
        obs_fet    = bus.perf_fetched;
        obs_bub    = bus.perf_bubbles;
        chk("im_rd_en", 32'(obs_rd_en), 32'(issue));
        if (issue) chk("im_addr", 32'(obs_addr), 32'(m_fpc));
        chk("if_valid", 32'(obs_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("if_pc", 32'(obs_pc), 32'(mq[0].pc));
            chk("if_instr", 32'(bus.if_instr), 32'(mq[0].instr));
        end
        chk("halted", 32'(obs_halted), 32'(m_halt));
        chk("perf_fetched", 32'(obs_fet), 32'(m_fet));
        chk("perf_bubbles", 32'(obs_bub), 32'(m_bub));
`ifdef IF_PERF_CNT_EN
        if (pop && m_fet != 16'hFFFF) m_fet++;
        if (rdy && mq.size() == 0 && !m_halt && m_bub != 16'hFFFF) m_bub++;
`endif
        if (pop) void'(mq.pop_front());
        hlt = 1'b0;
        if (mp.size() > 0) begin
            r = mp.pop_front();
            if (!r.disc && !rd) begin
                e.pc    = r.addr;
                e.instr = mem[r.addr];
                mq.push_back(e);
                hlt = (e.instr[15:12] == 4'hF);
            end
        end
        if (rd) begin
            mq.delete();
            m_fpc  = rpc;
            m_halt = 1'b0;
        end else begin
            if (issue) begin
                r.addr = m_fpc;
                r.disc = hlt;
                mp.push_back(r);
                m_fpc  = m_fpc + 16'd1;
            end
            if (hlt) m_halt = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.if_ready    = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_im_rd_en", 32'(bus.im_rd_en), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_halted", 32'(bus.halted), 32'd0);
        chk("rst_perf", {bus.perf_fetched, bus.perf_bubbles}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [15:0] seen [3];
        int          n;
        bit          found, seen3;
        logic [15:0] max_pc;

        for (int a = 0; a < 65536; a++) mem[a] = {4'(a % 15), 12'(a * 37)};
        rst = 1'b1;
        do_reset();

        // Reset release with decode always ready.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 16'h0);
            if (i == 0) begin
                chk("first_rd_en", 32'(obs_rd_en), 32'd1);
                chk("first_addr", 32'(obs_addr), 32'd0);
            end
            if (i == 1) chk("cycle2_valid", 32'(obs_valid), 32'd0);
            if (i >= 2) begin
                chk("stream_valid", 32'(obs_valid), 32'd1);
                chk("stream_pc", 32'(obs_pc), 32'(i - 2));
            end
        end

        // Back-pressure: queue fills with pcs 4,5 and fetch stops.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0);
        chk("stall_rd_en", 32'(obs_rd_en), 32'd0);
        chk("stall_pc", 32'(obs_pc), 32'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 16'h0);
            chk("release_pc", 32'(obs_pc), 32'(4 + i));
        end

        // Redirect with a read in flight.
        step(1'b1, 1'b1, 16'h0040);
        step(1'b1, 1'b0, 16'h0);
        chk("redir_no_stale", 32'(obs_valid), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(1'b1, 1'b0, 16'h0);
            if (obs_valid) begin
                found = 1'b1;
                chk("redir_first_pc", 32'(obs_pc), 32'h40);
            end
        end
        chk("redir_seen", 32'(found), 32'd1);

        // Halt at pc 3, then resume via redirect to 0x10.
        mem[3] = 16'hF000;
        do_reset();
        seen3  = 1'b0;
        max_pc = 16'h0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 16'h0);
            if (obs_valid && obs_pc == 16'h3) seen3 = 1'b1;
            if (obs_valid && obs_pc > max_pc) max_pc = obs_pc;
        end
        chk("halt_seen_pc3", 32'(seen3), 32'd1);
        chk("halt_max_pc", 32'(max_pc), 32'd3);
        chk("halt_flag", 32'(obs_halted), 32'd1);
        chk("halt_rd_en", 32'(obs_rd_en), 32'd0);
        step(1'b1, 1'b1, 16'h0010);
        step(1'b1, 1'b0, 16'h0);
        chk("resume_halted", 32'(obs_halted), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            step(1'b1, 1'b0, 16'h0);
            if (obs_valid) begin
                found = 1'b1;
                chk("resume_pc", 32'(obs_pc), 32'h10);
            end
        end
        chk("resume_seen", 32'(found), 32'd1);

        // Perf counters: 2 start-up bubbles, 10 pops, one post-redirect bubble.
        mem[3] = {4'(3 % 15), 12'(3 * 37)};
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b1, 16'h0100);
        step(1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched_10", 32'(obs_fet), 32'd10);
        chk("perf_bubbles_3", 32'(obs_bub), 32'd3);
`else
        chk("perf_fetched_off", 32'(obs_fet), 32'd0);
        chk("perf_bubbles_off", 32'(obs_bub), 32'd0);
`endif

        // PC wrap after redirect to 0xFFFF.
        step(1'b1, 1'b1, 16'hFFFF);
        n = 0;
        for (int i = 0; i < 10 && n < 3; i++) begin
            step(1'b1, 1'b0, 16'h0);
            if (obs_valid) begin
                seen[n] = obs_pc;
                n++;
            end
        end
        chk("wrap_count", 32'(n), 32'd3);
        chk("wrap_pc0", 32'(seen[0]), 32'hFFFF);
        chk("wrap_pc1", 32'(seen[1]), 32'h0000);
        chk("wrap_pc2", 32'(seen[2]), 32'h0001);

        // Random traffic with halts planted in the low region.
        for (int a = 0; a < 64; a++) if ($urandom_range(0, 9) == 0) mem[a] = 16'hF000 | 16'(a);
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            logic        rdy, rd;
            logic [15:0] rpc;
            rdy = ($urandom_range(0, 9) < 7);
            rd  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 7) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                              : 16'($urandom_range(0, 63));
            step(rdy, rd, rpc);
        end

        // Reset asserted mid-cycle clears everything immediately.
        bus.if_ready = 1'b1;
        bus.redirect = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_rd_en", 32'(bus.im_rd_en), 32'd0);
        chk("midrst_valid", 32'(bus.if_valid), 32'd0);
        chk("midrst_halted", 32'(bus.halted), 32'd0);
        chk("midrst_perf", {bus.perf_fetched, bus.perf_bubbles}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 1'b0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
